// File: rtl/pipe_reg_file.sv
// pipe_reg_file: register file with a per-register busy scoreboard and optional writeback forwarding.
module pipe_reg_file #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRD = 2,
    parameter int BYPASS = 1,
    localparam int AW = $clog2(NREG),
    localparam int CW = AW + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NRD-1:0]    rs_en,
    input  logic [NRD*AW-1:0] rs_addr,
    output logic [NRD*XLEN-1:0] rs_data,
    output logic [NRD-1:0]    rs_busy,
    output logic              stall,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [XLEN-1:0]   wdata,
    input  logic              iss_valid,
    input  logic [AW-1:0]     iss_rd,
    output logic [CW-1:0]     busy_cnt
);
    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy, busy_nxt;
    logic set, clr, inc, dec;

    // A set and clear of the same register leaves it busy: the new producer wins.
    always_comb begin
        set = iss_valid && iss_rd != '0;
        clr = we && waddr != '0;
        busy_nxt = busy;
        if (clr) busy_nxt[waddr] = 1'b0;
        if (set) busy_nxt[iss_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
        inc = set && !busy[iss_rd];
        dec = clr && busy[waddr] && !(set && iss_rd == waddr);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            busy <= '0;
            busy_cnt <= '0;
        end else begin
            if (clr) regs[waddr] <= wdata;
            busy <= busy_nxt;
            busy_cnt <= busy_cnt + CW'(inc) - CW'(dec);
        end
    end

    for (genvar g = 0; g < NRD; g++) begin : g_rd
        logic [AW-1:0] a;
        logic fwd;
        assign a = rs_addr[g*AW +: AW];
        assign fwd = BYPASS != 0 && clr && waddr == a;
        assign rs_data[g*XLEN +: XLEN] = !reset || a == '0 ? '0 : fwd ? wdata : regs[a];
        assign rs_busy[g] = reset && a != '0 && busy[a] && !fwd;
    end

    assign stall = |(rs_en & rs_busy);
endmodule

// File: tb/tb_pipe_reg_file.sv
// tb_pipe_reg_file: directed vectors checked through an expectation queue drained on the falling edge.
module tb_pipe_reg_file;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  rs_en = '0;
    logic [9:0]  rs_addr = '0;
    logic [63:0] rs_data, nb_data;
    logic [1:0]  rs_busy, nb_busy;
    logic        stall, nb_stall;
    logic        we = 1'b0;
    logic [4:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic        iss_valid = 1'b0;
    logic [4:0]  iss_rd = '0;
    logic [5:0]  busy_cnt, nb_cnt;

    typedef struct { string name; int sel; logic [31:0] val; } exp_t;
    exp_t q[$];
    int vectors = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_reg_file dut (
        .clk(clk), .reset(reset), .rs_en(rs_en), .rs_addr(rs_addr), .rs_data(rs_data),
        .rs_busy(rs_busy), .stall(stall), .we(we), .waddr(waddr), .wdata(wdata),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .busy_cnt(busy_cnt)
    );

    pipe_reg_file #(.BYPASS(0)) dut_nb (
        .clk(clk), .reset(reset), .rs_en(rs_en), .rs_addr(rs_addr), .rs_data(nb_data),
        .rs_busy(nb_busy), .stall(nb_stall), .we(we), .waddr(waddr), .wdata(wdata),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .busy_cnt(nb_cnt)
    );

    function automatic logic [31:0] probe(int sel);
        case (sel)
            0: return rs_data[31:0];
            1: return rs_data[63:32];
            2: return 32'(rs_busy[0]);
            3: return 32'(stall);
            4: return 32'(busy_cnt);
            5: return nb_data[63:32];
            6: return 32'(nb_cnt);
            7: return 32'(rs_busy[1]);
            default: return 32'hdead_beef;
        endcase
    endfunction

    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            logic [31:0] got;
            e = q.pop_front();
            got = probe(e.sel);
            vectors++;
            if (got !== e.val) begin
                errors++;
                $display("FAIL %s: got %0d, expected %0d at %0t", e.name, got, e.val, $time);
            end
        end
    end

    task automatic expect_v(string name, int sel, logic [31:0] val);
        q.push_back('{name, sel, val});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic w, logic [4:0] wa, logic [31:0] wd, logic iv, logic [4:0] ir);
        we = w; waddr = wa; wdata = wd; iss_valid = iv; iss_rd = ir;
    endtask

    initial begin
        #1;
        drive(1, 3, 55, 1, 4);
        rs_en = 2'b11; rs_addr = {5'd4, 5'd3};
        expect_v("reset_data_bypass", 0, 0);
        expect_v("reset_busy", 2, 0);
        expect_v("reset_stall", 3, 0);
        expect_v("reset_cnt", 4, 0);
        tick();
        reset = 1'b1;
        drive(0, 0, 0, 0, 0);
        expect_v("post_reset_data", 0, 0);
        expect_v("post_reset_cnt", 4, 0);
        expect_v("post_reset_busy4", 7, 0);
        tick();
        drive(1, 25, 1025, 0, 0);
        rs_addr = {5'd0, 5'd1};
        tick();
        drive(1, 0, 7, 0, 0);
        rs_addr = {5'd0, 5'd25};
        expect_v("read_r25", 0, 1025);
        expect_v("write_r0_bypass", 1, 0);
        expect_v("write_r0_nb", 5, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        rs_en = 2'b00;
        expect_v("read_r0", 1, 0);
        expect_v("busy_r0", 7, 0);
        tick();
        drive(1, 10, 100025, 0, 0);
        rs_en = 2'b11; rs_addr = {5'd10, 5'd25};
        expect_v("bypass_same_cycle", 1, 100025);
        expect_v("nobypass_old", 5, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        expect_v("bypass_next", 1, 100025);
        expect_v("nobypass_next", 5, 100025);
        tick();
        drive(0, 0, 0, 1, 12);
        rs_en = 2'b01; rs_addr = {5'd0, 5'd12};
        expect_v("issue_cycle_busy", 2, 0);
        expect_v("issue_cycle_cnt", 4, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        expect_v("sb_cnt1", 4, 1);
        expect_v("sb_busy12", 2, 1);
        expect_v("sb_stall", 3, 1);
        tick();
        drive(1, 12, 6545, 0, 0);
        expect_v("wb_stall_clear", 3, 0);
        expect_v("wb_busy_clear", 2, 0);
        expect_v("wb_data_fwd", 0, 6545);
        tick();
        drive(0, 0, 0, 0, 0);
        expect_v("wb_cnt0", 4, 0);
        expect_v("wb_cnt0_nb", 6, 0);
        expect_v("wb_data", 0, 6545);
        tick();
        drive(0, 0, 0, 1, 5);
        tick();
        drive(1, 5, 9, 1, 5);
        expect_v("sim_pre_cnt", 4, 1);
        tick();
        drive(1, 5, 11, 1, 7);
        rs_en = 2'b11; rs_addr = {5'd7, 5'd5};
        expect_v("sim_same_reg_cnt", 4, 1);
        tick();
        drive(0, 0, 0, 0, 0);
        expect_v("sim_diff_cnt", 4, 1);
        expect_v("sim_busy5", 2, 0);
        expect_v("sim_busy7", 7, 1);
        tick();
        drive(1, 7, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        expect_v("drain_cnt", 4, 0);
        for (int r = 1; r < 32; r++) begin
            drive(0, 0, 0, 1, 5'(r));
            tick();
        end
        drive(0, 0, 0, 1, 3);
        expect_v("sat_full", 4, 31);
        tick();
        drive(1, 9, 90, 0, 0);
        expect_v("sat_reissue", 4, 31);
        tick();
        drive(1, 9, 91, 0, 0);
        expect_v("clear_one", 4, 30);
        tick();
        drive(0, 0, 0, 0, 0);
        expect_v("clear_unbusy", 4, 30);
        for (int r = 5; r < 32; r++) begin
            drive(1, 5'(r), 32'(r * 3), 0, 0);
            tick();
        end
        drive(0, 0, 0, 0, 0);
        rs_en = 2'b11; rs_addr = {5'd2, 5'd20};
        expect_v("four_busy", 4, 4);
        expect_v("r20_data", 0, 60);
        expect_v("r2_busy", 7, 1);
        expect_v("r2_stall", 3, 1);
        tick();
        reset = 1'b0;
        drive(1, 20, 999, 1, 6);
        expect_v("midreset_data", 0, 0);
        expect_v("midreset_cnt", 4, 0);
        expect_v("midreset_stall", 3, 0);
        expect_v("midreset_busy", 7, 0);
        tick();
        reset = 1'b1;
        drive(0, 0, 0, 0, 0);
        expect_v("release_data", 0, 0);
        expect_v("release_cnt", 4, 0);
        tick();
        expect_v("release_no_write", 0, 0);
        expect_v("release_no_issue", 4, 0);
        tick();
        tick();
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/pipe_reg_file.md
PIPE_REG_FILE -- requirements
Module: pipe_reg_file

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data width per register.
REQ-002 SHALL have parameter NREG, default 32, meaning register count (power of two, >=4); AW = log2(NREG).
REQ-003 SHALL have parameter NRD, default 2, meaning number of read ports (1..4).
REQ-004 SHALL have parameter BYPASS, default 1, meaning write-to-read forwarding enable.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port rs_en  input  NRD  per-port read enable (port i = bit i).
REQ-008 SHALL have port rs_addr  input  NRD*AW  read addresses, port i at bits [i*AW +: AW].
REQ-009 SHALL have port rs_data  output  NRD*XLEN  read data, port i at bits [i*XLEN +: XLEN].
REQ-010 SHALL have port rs_busy  output  NRD  port i reads a register with a pending write.
REQ-011 SHALL have port stall  output  1  OR of (rs_en[i] & rs_busy[i]) over all ports.
REQ-012 SHALL have port we  input  1  writeback enable.
REQ-013 SHALL have port waddr  input  AW  writeback destination.
REQ-014 SHALL have port wdata  input  XLEN  writeback data.
REQ-015 SHALL have port iss_valid  input  1  an instruction with a destination issues this cycle.
REQ-016 SHALL have port iss_rd  input  AW  destination of issuing instruction.
REQ-017 SHALL have port busy_cnt  output  AW+1  number of registers currently marked busy.

Function
REQ-018 SHALL write wdata to register waddr on rising clk when we=1 and waddr!=0.
REQ-019 SHALL hold register 0 at zero permanently; writes to 0 ignored, reads of 0 return 0.
REQ-020 SHALL provide rs_data combinationally (zero-cycle read latency) from stored contents.
REQ-021 SHALL, when BYPASS=1 and we=1 and waddr==rs_addr[i]!=0, drive rs_data[i]=wdata in the same cycle.
REQ-022 SHALL, when BYPASS=0, return the pre-write stored value in the write cycle; new value visible next cycle.
REQ-023 SHALL keep one busy bit per register; bit 0 always 0.
REQ-024 SHALL set busy[iss_rd] on rising clk when iss_valid=1 and iss_rd!=0.
REQ-025 SHALL clear busy[waddr] on rising clk when we=1 and waddr!=0.
REQ-026 SHALL, when set and clear target the same register in one cycle, leave the bit set (new producer wins).
REQ-027 SHALL drive rs_busy[i]=busy[rs_addr[i]], except 0 when BYPASS=1 and the same-cycle writeback clears that register.
REQ-028 SHALL drive rs_busy[i]=0 whenever rs_addr[i]==0, irrespective of rs_en.
REQ-029 SHALL maintain busy_cnt as a registered counter: +1 on a 0->1 transition, -1 on a 1->0 transition, net 0 when both occur on different registers or none; never wraps (max NREG-1, min 0).
REQ-030 SHALL ignore a clear of a register whose busy bit is already 0 (no counter change).
REQ-031 SHALL ignore a set of a register already busy (no counter change; bit stays 1).
REQ-032 SHALL apply multiple read ports with the same address identically and independently.

Reset
REQ-033 SHALL, while reset=0, asynchronously force all registers to 0, all busy bits to 0, busy_cnt to 0.
REQ-034 SHALL, while reset=0, output rs_data=0, rs_busy=0, stall=0 for all ports.
REQ-035 SHALL ignore we and iss_valid while reset=0; first update occurs on the first rising clk after reset returns to 1.
REQ-036 SHALL, on reset assertion mid-operation (pending busy bits, write in flight), discard all state with no partial write.

Verification
REQ-037 Write/read: we=1,waddr=25,wdata=1025; next cycle rs_addr[0]=25 -> rs_data[0]=1025; write waddr=0,wdata=7 -> rs_data reading 0 = 0.
REQ-038 Bypass: BYPASS=1, we=1,waddr=10,wdata=100025, rs_addr[1]=10 same cycle -> rs_data[1]=100025; BYPASS=0 build -> old value 0 that cycle, 100025 next.
REQ-039 Scoreboard: iss_valid=1,iss_rd=12 -> next cycle busy_cnt=1, rs_en[0]=1,rs_addr[0]=12 -> rs_busy[0]=1, stall=1; we=1,waddr=12,wdata=6545 -> stall=0 same cycle (BYPASS=1), busy_cnt=0 next cycle.
REQ-040 Simultaneous: busy[5]=1; iss_valid=1,iss_rd=5 and we=1,waddr=5 same edge -> busy[5] stays 1, busy_cnt unchanged; issue 7 while writeback 5 -> busy_cnt unchanged, busy[7]=1, busy[5]=0.
REQ-041 Saturation: issue all registers 1..NREG-1 -> busy_cnt=NREG-1; reissue 3 -> busy_cnt unchanged; clear unbusy register -> unchanged.
REQ-042 Reset mid-run: registers written, 4 busy, drive reset=0 between edges -> immediately rs_data=0, busy_cnt=0, stall=0; we=1 asserted during reset has no effect after release.
